// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port: ALU/CSR (req0)
// and LSU load (req1) write-backs, one registered write per cycle, x0 writes dropped.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    // Handshake: a write transfers on the rising edge where reqN_valid and
    // reqN_ready are both 1; ready never depends on anything but the valids,
    // prio and rst, and a requester holds valid/addr/data until it sees ready.

    logic                  prio;       // 0: req0 preferred on contention, 1: req1
    logic                  both_valid;
    logic                  grant0;
    logic                  grant1;
    logic                  wen_q;

    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        both_valid = req0_valid & req1_valid;
        if (!rst) begin
            if (both_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant0) begin
            wen_q    <= (req0_addr != '0);
            rf_waddr <= req0_addr;
            rf_wdata <= req0_data;
        end else if (grant1) begin
            wen_q    <= (req1_addr != '0);
            rf_waddr <= req1_addr;
            rf_wdata <= req1_data;
        end else begin
            wen_q    <= 1'b0;
        end
    end

    // Masking with rst keeps a write that is still in flight when reset
    // arrives from landing in the register file on the reset edge.
    assign rf_wen = wen_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (both_valid && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (wen/waddr/wdata) between two write-back requesters: req0 is ALU/CSR write-back, req1 is LSU load write-back.
- Arbitration is round-robin over valid/ready handshakes.
- Registers the winning write one cycle before it is presented to the register file.
- Drops writes to x0 and counts contention cycles for performance debug.
- Sits between the execute/LSU stages and RegisterFile in the NPC.

Parameters:
ADDR_WIDTH, 5, register index width (32 architectural registers)
DATA_WIDTH, 64, write data width; must match RegisterFile DATA_WIDTH
CNT_WIDTH, 16, width of the saturating contention counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has a write pending
req0_ready  output  1  requester 0 write accepted this cycle
req0_addr  input  ADDR_WIDTH  requester 0 destination register
req0_data  input  DATA_WIDTH  requester 0 write data
req1_valid  input  1  requester 1 has a write pending
req1_ready  output  1  requester 1 write accepted this cycle
req1_addr  input  ADDR_WIDTH  requester 1 destination register
req1_data  input  DATA_WIDTH  requester 1 write data
rf_wen  output  1  register file write enable (registered)
rf_waddr  output  ADDR_WIDTH  register file write address (registered)
rf_wdata  output  DATA_WIDTH  register file write data (registered)
conflict_cnt  output  CNT_WIDTH  cycles in which both requesters were valid, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Priority pointer prio=0, meaning req0 is preferred.
  - conflict_cnt=0.
  - req*_ready are forced to 0 while rst=1.
- Grant is combinational from the valids and prio; reqN_ready = grantN. At most one grant per cycle.
  - Only req0 valid: grant0.
  - Only req1 valid: grant1.
  - Both valid: grant goes to the requester selected by prio.
  - Neither valid: no grant.
- Pointer update: after any grant, prio points to the non-granted requester at the next edge. With no grant, prio holds.
- Requester rules: once valid is asserted, the requester keeps valid, addr and data stable until it sees ready=1. Behaviour on violation is undefined.
- Output stage, latency 1 cycle:
  - Handshake at edge N → rf_waddr/rf_wdata take the granted addr/data at edge N.
  - rf_wen=1 during cycle N+1 only if the granted addr != 0.
  - A write to x0 is accepted (ready=1) but rf_wen stays 0. rf_waddr/rf_wdata still update.
  - No handshake → rf_wen=0 next cycle; rf_waddr/rf_wdata hold their previous values.
- Throughput is one write per cycle with no bubbles. Back-to-back grants to the same or different requesters are allowed.
- Same destination on both requesters in the same cycle: the two writes are serialized in grant order, and the later write wins in the register file. No merging is done.
- conflict_cnt increments by 1 on each edge where req0_valid & req1_valid & !rst. It saturates at all-ones and does not wrap.
- Reset mid-operation:
  - A write registered but not yet seen by the register file is discarded (rf_wen=0 after reset).
  - Requesters still holding valid are re-arbitrated from prio=0 after rst deasserts.

Test Plan:
- Reset, then rst=0 with both valids low for 3 cycles → rf_wen=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, both ready=0.
- req0 only, addr=5, data=0x1234 for 1 cycle → req0_ready=1 same cycle. Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234. Following cycle rf_wen=0 with addr/data held.
- Both valid from reset for 4 cycles; req0 writes addr 1,2, req1 writes addr 3,4, each requester advancing on its ready → grants alternate req0,req1,req0,req1. rf_waddr sequence is 1,3,2,4, each with rf_wen=1. conflict_cnt=4.
- req1 only, addr=0, data=0xFFFF → req1_ready=1. Next cycle rf_wen=0, rf_waddr=0, rf_wdata=0xFFFF.
- Both valid with the same addr=7 (req0 data=0xA, req1 data=0xB), prio=1 → req1 granted first, then req0. RegisterFile x7 ends at 0xA.
- rst asserted in the cycle after a req0 handshake (addr=9) → rf_wen=0 after the reset edge and no write to x9 occurs. With req1 held valid through reset, req1_ready=0 during rst and 1 in the first cycle after.
- Both valid held for 2^CNT_WIDTH+3 cycles (CNT_WIDTH=4 build) → conflict_cnt stops at 15 and never wraps.
